// File: rtl/simplebus_pkg.sv
// Shared SimpleBus command encodings, slave FSM states and default geometry.
// Used by the memory slave and by any bench that talks SimpleBus.
package simplebus_pkg;

   localparam logic [3:0] CMD_READ        = 4'b0000;
   localparam logic [3:0] CMD_WRITE       = 4'b0001;
   localparam logic [3:0] CMD_READ_BURST  = 4'b0010;
   localparam logic [3:0] CMD_WRITE_BURST = 4'b0011;
   localparam logic [3:0] CMD_WRITE_LAST  = 4'b0111;
   localparam logic [3:0] CMD_READ_LAST   = 4'b0110;
   localparam logic [3:0] CMD_WRITE_RESP  = 4'b0101;

   localparam int DEF_MEM_WORDS    = 4096;
   localparam int DEF_BURST_BEATS  = 8;
   localparam int DEF_READ_LATENCY = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RWAIT,
      ST_RBEAT,
      ST_WBURST,
      ST_WRESP
   } state_e;

endpackage

// File: rtl/simplebus_mem_ram.sv
// 64-bit wide 1R1W RAM: synchronous byte-masked write, combinational read.
module simplebus_mem_ram #(
   parameter int WORDS = 4096,
   parameter int AW    = $clog2(WORDS)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [7:0]    wmask_i,
   input  logic [63:0]   wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [63:0]   rdata_o
);

   logic [63:0] mem_q [WORDS];

   // NOTE: the storage array has no reset; contents must survive a bus reset
   // and a reset port would prevent mapping onto a RAM macro.
   always_ff @(posedge clk) begin
      if (we_i) begin
         for (int k = 0; k < 8; k++) begin
            if (wmask_i[k]) begin
               mem_q[waddr_i][8*k +: 8] <= wdata_i[8*k +: 8];
            end
         end
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/simplebus_mem_slave.sv
// SimpleBus memory slave: single/burst reads and writes, fixed read latency,
// critical-word-first burst ordering and full ready/valid backpressure.
module simplebus_mem_slave
   import simplebus_pkg::*;
#(
   parameter int MEM_WORDS    = DEF_MEM_WORDS,
   parameter int BURST_BEATS  = DEF_BURST_BEATS,
   parameter int READ_LATENCY = DEF_READ_LATENCY
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [2:0]  req_size,
   input  logic [3:0]  req_cmd,
   input  logic [7:0]  req_wmask,
   input  logic [63:0] req_wdata,
   input  logic [15:0] req_user,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [3:0]  resp_cmd,
   output logic [63:0] resp_rdata,
   output logic [15:0] resp_user
);

   localparam int AW = $clog2(MEM_WORDS);
   localparam int BW = $clog2(BURST_BEATS);
   localparam int CW = $clog2(READ_LATENCY + 1);
   localparam logic [BW-1:0] LAST_BURST_BEAT = BW'(BURST_BEATS - 1);
   localparam logic [CW-1:0] WAIT_LOAD       = (READ_LATENCY > 1) ? CW'(READ_LATENCY - 2) : '0;

   state_e        state_q, state_d;
   logic [AW-1:0] base_q, base_d;
   logic [BW-1:0] beat_q, beat_d;
   logic [BW-1:0] last_beat_q, last_beat_d;
   logic [15:0]   user_q, user_d;
   logic [CW-1:0] lat_q, lat_d;
   logic          zero_q, zero_d;

   logic          accept;
   logic [AW-1:0] req_word;
   logic [BW-1:0] beat_off;
   logic [AW-1:0] line_addr;
   logic          ram_we;
   logic [AW-1:0] ram_waddr;
   logic [63:0]   ram_rdata;
   logic          unused_req_bits;

   assign req_ready = !rst && (state_q == ST_IDLE || state_q == ST_WBURST);
   assign accept    = req_valid && req_ready;
   assign req_word  = req_addr[3 +: AW];

   // Beats wrap inside the aligned line, so only the low BW bits advance.
   assign beat_off  = base_q[BW-1:0] + beat_q;
   assign line_addr = {base_q[AW-1:BW], beat_off};

   assign unused_req_bits = ^{req_size, req_addr[2:0], req_addr[31:3+AW]};

   simplebus_mem_ram #(
      .WORDS (MEM_WORDS),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .waddr_i (ram_waddr),
      .wmask_i (req_wmask),
      .wdata_i (req_wdata),
      .raddr_i (line_addr),
      .rdata_o (ram_rdata)
   );

   // NOTE: every signal written here gets a default first so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      beat_d      = beat_q;
      last_beat_d = last_beat_q;
      user_d      = user_q;
      lat_d       = lat_q;
      zero_d      = zero_q;
      ram_we      = 1'b0;
      ram_waddr   = req_word;
      resp_valid  = 1'b0;
      resp_cmd    = 4'b0000;
      resp_rdata  = 64'd0;
      resp_user   = 16'd0;

      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               base_d      = req_word;
               beat_d      = '0;
               last_beat_d = '0;
               user_d      = req_user;
               zero_d      = 1'b0;
               unique case (req_cmd)
                  CMD_WRITE, CMD_WRITE_LAST: begin
                     ram_we  = 1'b1;
                     state_d = ST_WRESP;
                  end
                  CMD_WRITE_BURST: begin
                     ram_we  = 1'b1;
                     beat_d  = BW'(1);
                     state_d = ST_WBURST;
                  end
                  default: begin
                     // Reads and unknown commands share the latency path;
                     // unknown ones return a single zero beat.
                     if (req_cmd == CMD_READ_BURST) begin
                        last_beat_d = LAST_BURST_BEAT;
                     end
                     zero_d = (req_cmd != CMD_READ) && (req_cmd != CMD_READ_BURST);
                     lat_d  = WAIT_LOAD;
                     state_d = (READ_LATENCY > 1) ? ST_RWAIT : ST_RBEAT;
                  end
               endcase
            end
         end

         ST_RWAIT: begin
            if (lat_q == '0) begin
               state_d = ST_RBEAT;
            end else begin
               lat_d = lat_q - CW'(1);
            end
         end

         ST_RBEAT: begin
            resp_valid = 1'b1;
            resp_cmd   = (beat_q == last_beat_q) ? CMD_READ_LAST : CMD_READ_BURST;
            resp_rdata = zero_q ? 64'd0 : ram_rdata;
            resp_user  = user_q;
            if (resp_ready) begin
               if (beat_q == last_beat_q) begin
                  beat_d  = '0;
                  state_d = ST_IDLE;
               end else begin
                  beat_d = beat_q + BW'(1);
               end
            end
         end

         ST_WBURST: begin
            if (accept) begin
               ram_we    = 1'b1;
               ram_waddr = line_addr;
               beat_d    = beat_q + BW'(1);
               if (req_cmd == CMD_WRITE_LAST) begin
                  state_d = ST_WRESP;
               end
            end
         end

         ST_WRESP: begin
            resp_valid = 1'b1;
            resp_cmd   = CMD_WRITE_RESP;
            resp_user  = user_q;
            if (resp_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         base_q      <= '0;
         beat_q      <= '0;
         last_beat_q <= '0;
         user_q      <= '0;
         lat_q       <= '0;
         zero_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         beat_q      <= beat_d;
         last_beat_q <= last_beat_d;
         user_q      <= user_d;
         lat_q       <= lat_d;
         zero_q      <= zero_d;
      end
   end

endmodule

// File: tb/tb_simplebus_mem_slave.sv
// Scoreboard bench for simplebus_mem_slave: a driver pushes expected responses
// from a word-array memory model, a monitor pops and compares on handshakes.
module tb_simplebus_mem_slave;
   import simplebus_pkg::*;

   localparam int MEM_WORDS = 4096;
   localparam int BB        = 8;
   localparam int LAT       = 2;

   logic        clk, rst;
   logic        req_valid, req_ready;
   logic [31:0] req_addr;
   logic [2:0]  req_size;
   logic [3:0]  req_cmd;
   logic [7:0]  req_wmask;
   logic [63:0] req_wdata;
   logic [15:0] req_user;
   logic        resp_valid, resp_ready;
   logic [3:0]  resp_cmd;
   logic [63:0] resp_rdata;
   logic [15:0] resp_user;

   simplebus_mem_slave #(
      .MEM_WORDS    (MEM_WORDS),
      .BURST_BEATS  (BB),
      .READ_LATENCY (LAT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_size   (req_size),
      .req_cmd    (req_cmd),
      .req_wmask  (req_wmask),
      .req_wdata  (req_wdata),
      .req_user   (req_user),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_cmd   (resp_cmd),
      .resp_rdata (resp_rdata),
      .resp_user  (resp_user)
   );

   typedef struct {
      logic [3:0]  cmd;
      logic [63:0] rdata;
      logic [15:0] user;
      bit          first;
      bit          last;
      int          vcycle;
   } exp_t;

   exp_t        exp_q[$];
   logic [63:0] mem_m [MEM_WORDS];
   int          checks, errors;
   int          cyc;
   int          rr_mode;
   int          beats_seen;
   bit          busy;
   bit          wb_active;
   int unsigned wb_word, wb_beat;
   logic [15:0] wb_user;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic int unsigned beat_word(input int unsigned w, input int unsigned j);
      return (w / BB) * BB + ((w % BB) + j) % BB;
   endfunction

   function automatic void mem_write(input int unsigned w, input logic [7:0] m, input logic [63:0] d);
      for (int k = 0; k < 8; k++) begin
         if (m[k]) mem_m[w][8*k +: 8] = d[8*k +: 8];
      end
   endfunction

   function automatic void push(input logic [3:0] c, input logic [63:0] d, input logic [15:0] u,
                                input bit f, input bit l, input int vc);
      exp_t e;
      e.cmd = c; e.rdata = d; e.user = u; e.first = f; e.last = l; e.vcycle = vc;
      exp_q.push_back(e);
   endfunction

   // Reference behaviour of one accepted request; returns 1 when a response is owed.
   function automatic bit model_accept(input logic [3:0] c, input logic [31:0] a, input logic [7:0] m,
                                       input logic [63:0] d, input logic [15:0] u, input int t);
      int unsigned w = (a >> 3) % MEM_WORDS;
      int unsigned n;
      if (wb_active) begin
         mem_write(beat_word(wb_word, wb_beat), m, d);
         wb_beat++;
         if (c == CMD_WRITE_LAST) begin
            wb_active = 1'b0;
            push(CMD_WRITE_RESP, 64'd0, wb_user, 1'b1, 1'b1, t + 1);
            return 1'b1;
         end
         return 1'b0;
      end
      if (c == CMD_WRITE || c == CMD_WRITE_LAST) begin
         mem_write(w, m, d);
         push(CMD_WRITE_RESP, 64'd0, u, 1'b1, 1'b1, t + 1);
         return 1'b1;
      end
      if (c == CMD_WRITE_BURST) begin
         mem_write(w, m, d);
         wb_active = 1'b1; wb_word = w; wb_beat = 1; wb_user = u;
         return 1'b0;
      end
      if (c == CMD_READ || c == CMD_READ_BURST) begin
         n = (c == CMD_READ_BURST) ? BB : 1;
         for (int unsigned j = 0; j < n; j++) begin
            push((j == n - 1) ? CMD_READ_LAST : CMD_READ_BURST, mem_m[beat_word(w, j)], u,
                 j == 0, j == n - 1, t + LAT);
         end
         return 1'b1;
      end
      push(CMD_READ_LAST, 64'd0, u, 1'b1, 1'b1, t + LAT);
      return 1'b1;
   endfunction

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [7:0] m,
                       input logic [63:0] d, input logic [15:0] u);
      bit accepted = 1'b0;
      bit owes     = 1'b0;
      int n        = 0;
      req_valid = 1'b1; req_cmd = c; req_addr = a; req_wmask = m; req_wdata = d; req_user = u;
      req_size  = 3'($urandom);
      while (!accepted && n < 300) begin
         @(negedge clk);
         if (req_ready) begin
            accepted = 1'b1;
            owes     = model_accept(c, a, m, d, u, cyc);
         end else begin
            n++;
         end
      end
      if (!accepted) begin
         checks++; errors++;
         $display("FAIL req_accept_timeout: cmd %h not accepted within 300 cycles", c);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_wdata = 64'($urandom);
      if (owes) busy = 1'b1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < 500) begin
         @(posedge clk); n++;
      end
      #1;
      if (n >= 500) begin
         checks++; errors++;
         $display("FAIL drain_timeout: %0d responses still expected", exp_q.size());
      end
   endtask

   task automatic burst_write(input logic [31:0] a, input logic [15:0] u, input bit rnd);
      for (int i = 0; i < BB; i++) begin
         send((i == 0) ? CMD_WRITE_BURST : ((i == BB - 1) ? CMD_WRITE_LAST : CMD_WRITE_BURST),
              (i == 0) ? a : 32'($urandom), rnd ? 8'($urandom) : 8'hFF,
              rnd ? {32'($urandom), 32'($urandom)} : 64'(i), u);
      end
   endtask

   // resp_ready generator: 0 always ready, 1 toggle, 2 random, 3 held low
   initial begin
      resp_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (rr_mode)
            0:       resp_ready = 1'b1;
            1:       resp_ready = ~resp_ready;
            2:       resp_ready = 1'($urandom_range(0, 1));
            default: resp_ready = 1'b0;
         endcase
      end
   end

   // Monitor: compares each response beat against the head of the scoreboard.
   initial begin
      exp_t        e;
      bit          prev_v = 1'b0;
      bit          hold   = 1'b0;
      logic [3:0]  h_cmd;
      logic [63:0] h_rdata;
      logic [15:0] h_user;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_v = 1'b0;
            hold   = 1'b0;
            continue;
         end
         if (busy) check("req_ready_while_busy", req_ready, 1'b0);
         if (hold) check("resp_valid_held", resp_valid, 1'b1);
         if (resp_valid) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_resp: cmd %h user %h with empty scoreboard", resp_cmd, resp_user);
            end else begin
               e = exp_q[0];
               if (!prev_v) begin
                  check("resp_starts_on_first_beat", e.first, 1'b1);
                  check("resp_first_cycle", cyc, e.vcycle);
               end
               if (hold) begin
                  check("stall_cmd_stable", resp_cmd, h_cmd);
                  check("stall_rdata_stable", resp_rdata, h_rdata);
                  check("stall_user_stable", resp_user, h_user);
               end
               if (resp_ready) begin
                  void'(exp_q.pop_front());
                  check("resp_cmd", resp_cmd, e.cmd);
                  check("resp_rdata", resp_rdata, e.rdata);
                  check("resp_user", resp_user, e.user);
                  beats_seen++;
                  if (e.last) busy = 1'b0;
                  hold = 1'b0;
               end else begin
                  hold = 1'b1;
                  h_cmd = resp_cmd; h_rdata = resp_rdata; h_user = resp_user;
               end
            end
         end else begin
            hold = 1'b0;
         end
         prev_v = resp_valid;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned w;
      int          target;
      int          n;
      int unsigned op;
      logic [31:0] a;

      checks = 0; errors = 0; cyc = 0; rr_mode = 0; beats_seen = 0;
      busy = 1'b0; wb_active = 1'b0;
      for (int i = 0; i < MEM_WORDS; i++) mem_m[i] = 64'd0;
      rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_size = '0; req_cmd = '0;
      req_wmask = '0; req_wdata = '0; req_user = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", req_ready, 1'b0);
      check("rst_resp_valid", resp_valid, 1'b0);
      check("rst_resp_cmd", resp_cmd, 4'd0);
      check("rst_resp_rdata", resp_rdata, 64'd0);
      check("rst_resp_user", resp_user, 16'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("post_rst_req_ready", req_ready, 1'b1);
      @(posedge clk); #1;

      // Single write then read back
      send(CMD_WRITE, 32'h1000, 8'hFF, 64'h1122334455667788, 16'h005A);
      send(CMD_READ, 32'h1000, 8'h00, 64'd0, 16'h0011);

      // Byte masking, including an all-zero mask
      send(CMD_WRITE, 32'h3000, 8'hFF, 64'd0, 16'h0001);
      send(CMD_WRITE, 32'h3000, 8'h0F, 64'hFFFFFFFFFFFFFFFF, 16'h0002);
      send(CMD_READ, 32'h3000, 8'h00, 64'd0, 16'h0003);
      send(CMD_WRITE, 32'h3000, 8'h00, 64'hDEADBEEFDEADBEEF, 16'h0004);
      send(CMD_READ, 32'h3000, 8'h00, 64'd0, 16'h0005);

      // Burst write of beat indices, critical-word-first read from beat 3
      burst_write(32'h2000, 16'h0020, 1'b0);
      send(CMD_READ_BURST, 32'h2018, 8'h00, 64'd0, 16'h0021);
      wait_idle();

      // Backpressure toggling every other cycle
      rr_mode = 1;
      send(CMD_READ_BURST, 32'h2000, 8'h00, 64'd0, 16'h0030);
      wait_idle();
      rr_mode = 0;
      @(posedge clk); #1;

      // Reset in the middle of a read burst
      target = beats_seen + 3;
      send(CMD_READ_BURST, 32'h2000, 8'h00, 64'd0, 16'h0040);
      n = 0;
      while (beats_seen < target && n < 100) begin
         @(posedge clk); n++;
      end
      if (n >= 100) begin
         checks++; errors++;
         $display("FAIL mid_burst_wait: only %0d of %0d beats seen", beats_seen, target);
      end
      #2;
      rr_mode = 3; resp_ready = 1'b0; rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("midrst_resp_valid", resp_valid, 1'b0);
      check("midrst_req_ready", req_ready, 1'b0);
      exp_q.delete();
      busy = 1'b0; wb_active = 1'b0;
      @(posedge clk); #1 rst = 1'b0; rr_mode = 0;
      @(negedge clk);
      check("midrst_release_req_ready", req_ready, 1'b1);
      @(posedge clk); #1;
      send(CMD_READ_BURST, 32'h2000, 8'h00, 64'd0, 16'h0041);

      // Unsupported command: zero readLast, memory untouched
      send(4'b1000, 32'h2000, 8'hFF, 64'hCAFEF00DCAFEF00D, 16'h0077);
      send(CMD_READ, 32'h2000, 8'h00, 64'd0, 16'h0078);
      wait_idle();

      // Randomized traffic over an initialised window with aliased upper bits
      for (int l = 0; l < 8; l++) burst_write(32'h1000 + 32'(l * 64), 16'(l), 1'b1);
      wait_idle();
      rr_mode = 2;
      for (int i = 0; i < 80; i++) begin
         w  = 32'h200 + $urandom_range(0, 63);
         a  = ($urandom & 32'hFFFF_8000) | (32'(w) << 3) | 32'($urandom_range(0, 7));
         op = $urandom_range(0, 4);
         case (op)
            0: send(CMD_WRITE, a, 8'($urandom), {32'($urandom), 32'($urandom)}, 16'($urandom));
            1: send(CMD_READ, a, 8'h00, 64'd0, 16'($urandom));
            2: send(CMD_READ_BURST, a, 8'h00, 64'd0, 16'($urandom));
            3: burst_write(a, 16'($urandom), 1'b1);
            default: send(CMD_WRITE_LAST, a, 8'($urandom), {32'($urandom), 32'($urandom)}, 16'($urandom));
         endcase
      end
      wait_idle();
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/simplebus_mem_slave.md
# simplebus_mem_slave

SimpleBus slave memory model that sits directly downstream of the cache's memory-side SimpleBus port and services its refills and write-backs. It accepts single and burst reads/writes, stores data in an internal 64-bit-wide RAM, and returns responses with a programmable fixed latency and full ready/valid backpressure. It is the synthesizable end-point the cache bench connects to in place of a real memory controller.

## Interface
- MEM_WORDS, 4096, RAM depth in 64-bit words; word index = req_addr[3+:log2(MEM_WORDS)]
- BURST_BEATS, 8, beats per burst (cache line = BURST_BEATS*8 bytes); power of two
- READ_LATENCY, 2, cycles from read acceptance to first resp_valid (≥1)
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&&ready
- req_addr  in  32  byte address
- req_size  in  3  ignored (wmask governs bytes)
- req_cmd  in  4  0000 read, 0001 write, 0010 readBurst, 0011 writeBurst, 0111 writeLast
- req_wmask  in  8  byte enables
- req_wdata  in  64  write data
- req_user  in  16  tag, echoed on response
- resp_valid  out  1  response valid
- resp_ready  in  1  response consumed when valid&&ready
- resp_cmd  out  4  0010 readBurst (non-last beat), 0110 readLast, 0101 writeResp
- resp_rdata  out  64  read data
- resp_user  out  16  req_user of the first request beat

## Operation
- States: IDLE, RWAIT, RBEAT, WBURST, WRESP.
- IDLE: req_ready=1. On accept: read/readBurst → latch base word, beat count (1 or BURST_BEATS), user; load latency counter; → RWAIT. write → apply masked write; → WRESP. writeBurst → masked write at base word, beat idx=1; → WBURST. writeLast in IDLE → treated as single write. Any other cmd → no memory effect, single readLast beat with rdata=0 (via RWAIT).
- RWAIT: req_ready=0; counter decrements; at zero → RBEAT.
- RBEAT: resp_valid=1; rdata = RAM[line_base | ((start_beat+i) mod BURST_BEATS)] (critical-word-first, wraps within line). resp_cmd=0110 on last beat else 0010. On handshake advance i; after last → IDLE.
- WBURST: req_ready=1; each accepted beat writes RAM[line_base | ((start_beat+i) mod BURST_BEATS)] with wmask; beat addr ignored. writeLast beat → WRESP. A read/write cmd in WBURST is accepted and treated as a burst beat (protocol error, not checked).
- WRESP: resp_valid=1, resp_cmd=0101, rdata=0; on handshake → IDLE.
- Masked write: byte k updated iff wmask[k]; wmask=0 leaves word unchanged.
- Index arithmetic modulo MEM_WORDS; addresses above range alias.

## Timing
- Reset: state IDLE, req_ready=1 next cycle after rst deasserted (0 while rst=1), resp_valid=0, resp_cmd=0, resp_rdata=0, resp_user=0, counters 0.
- Read: accept at cycle T → first resp_valid at T+READ_LATENCY; subsequent beats back-to-back when resp_ready=1.
- Write: accept at T (or writeLast at T) → resp_valid at T+1.
- Stall: while resp_valid && !resp_ready, resp_cmd/rdata/user held stable; beat not advanced.
- One outstanding transaction; no new request accepted until response handshake completes.
- RAM write visible to a read accepted the cycle after the write.
- rst mid-transaction: abort, return to IDLE, outputs to reset values; RAM contents retained (zero at time 0, never cleared by rst).

## Structure
- Package simplebus_pkg: cmd localparams (CMD_READ, CMD_WRITE, CMD_READ_BURST, CMD_WRITE_BURST, CMD_WRITE_LAST, CMD_READ_LAST, CMD_WRITE_RESP), state enum, shared with the cache bench.
- Sub-module simplebus_mem_ram: 1R1W synchronous-write, combinational-read, byte-masked RAM; FSM in top level.

## Test plan
- Single write 0x1000 data 0x1122334455667788 wmask 0xFF user 0x5A → writeResp (0101) user 0x5A one cycle later; read 0x1000 → rdata 0x1122334455667788, cmd 0110, resp_valid at READ_LATENCY.
- Masked write wmask 0x0F data 0xFFFFFFFFFFFFFFFF over 0 → read returns 0x00000000FFFFFFFF.
- writeBurst base 0x2000 beats data i, then readBurst 0x2018 → beats 3,4,5,6,7,0,1,2; cmd 0010 ×7 then 0110.
- readBurst with resp_ready toggled every other cycle → each beat held stable until handshake, 8 beats total, req_ready=0 throughout.
- rst asserted on beat 3 of readBurst → resp_valid=0 next cycle, req_ready=1 after release, subsequent read of burst data unchanged.
- Unsupported cmd 1000 user 0x77 → single beat cmd 0110 rdata 0 user 0x77, memory unchanged.
